// File: rtl/signed_compare_unit.sv
// Signed N-bit comparator: XNOR-reduce equality and ripple-subtract less-than,
// offered both combinationally and through a one-cycle registered stage.
module signed_compare_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         equals,
    output logic         less_than,
    output logic         equals_q,
    output logic         less_than_q
);

    logic [N-1:0] eq_bits;
    logic [N-1:0] b_inv;
    logic [N-1:0] diff;
    logic [N-1:0] carry;
    logic         sign_differs;
    logic         ovf;

    assign eq_bits = ~(a ^ b);
    assign equals  = &eq_bits;

    // a - b computed as a + ~b + 1 through a full-adder chain
    assign b_inv    = ~b;
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign diff[i] = a[i] ^ b_inv[i] ^ carry[i];
        if (i < N - 1) begin : g_cy
            assign carry[i+1] = (a[i] & b_inv[i])
                              | (carry[i] & (a[i] ^ b_inv[i]));
        end
    end

    // overflow only when signs differ and the result sign departs from a
    assign sign_differs = a[N-1] ^ b[N-1];
    assign ovf          = sign_differs & (diff[N-1] ^ a[N-1]);
    assign less_than    = diff[N-1] ^ ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            equals_q    <= 1'b0;
            less_than_q <= 1'b0;
        end else begin
            equals_q    <= equals;
            less_than_q <= less_than;
        end
    end

endmodule

// File: tb/tb_signed_compare_unit.sv
// Scoreboard bench for signed_compare_unit: directed vectors plus random pairs,
// checking combinational outputs and the one-cycle registered outputs.
module tb_signed_compare_unit;

    localparam int N = 32;

    typedef struct {
        logic        rst;
        logic [31:0] a;
        logic [31:0] b;
        logic        eq;
        logic        lt;
        logic        eq_q;
        logic        lt_q;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic        equals;
    logic        less_than;
    logic        equals_q;
    logic        less_than_q;

    exp_t sb[$];
    int   n_cmp;
    int   n_fail;
    bit   driver_done;

    signed_compare_unit #(.N(N)) dut (
        .clk(clk),
        .rst(rst),
        .a(a),
        .b(b),
        .equals(equals),
        .less_than(less_than),
        .equals_q(equals_q),
        .less_than_q(less_than_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (a=%h b=%h)",
                     name, act, exp, a, b);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] va,
                         input logic [31:0] vb, input logic eq,
                         input logic lt, input string name);
        exp_t e;
        @(negedge clk);
        rst = r;
        a   = va;
        b   = vb;
        e.rst  = r;
        e.a    = va;
        e.b    = vb;
        e.eq   = eq;
        e.lt   = lt;
        e.eq_q = r ? 1'b0 : eq;
        e.lt_q = r ? 1'b0 : lt;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: registered outputs must hold until the next edge, then
    // reflect the comparison presented before that edge.
    initial begin : monitor
        exp_t r;
        exp_t prev;
        bit   have_prev;
        have_prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (have_prev) begin
                chk({prev.name, "/hold_eq_q"}, equals_q, prev.eq_q);
                chk({prev.name, "/hold_lt_q"}, less_than_q, prev.lt_q);
            end
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                r = sb.pop_front();
                chk({r.name, "/eq"}, equals, r.eq);
                chk({r.name, "/lt"}, less_than, r.lt);
                chk({r.name, "/eq_q"}, equals_q, r.eq_q);
                chk({r.name, "/lt_q"}, less_than_q, r.lt_q);
                chk({r.name, "/excl"}, equals & less_than, 1'b0);
                prev      = r;
                have_prev = 1'b1;
            end else begin
                have_prev = 1'b0;
            end
        end
    end

    initial begin : driver
        logic [31:0] ra;
        logic [31:0] rb;
        int          waited;
        n_cmp       = 0;
        n_fail      = 0;
        driver_done = 1'b0;
        rst = 1'b1;
        a   = '0;
        b   = '0;

        drive(1, 32'd0, 32'd0, 1, 0, "rst_hold0");
        drive(1, 32'd0, 32'd0, 1, 0, "rst_hold1");
        drive(0, 32'd0, 32'd0, 1, 0, "zero_eq");
        drive(0, 32'd38273, 32'd38273, 1, 0, "eq_38273");
        drive(0, 32'hFFFF_FFFF, 32'd1, 0, 1, "m1_lt_1");
        drive(0, 32'd1, 32'd2, 0, 1, "1_lt_2");
        drive(0, 32'd2, 32'd1, 0, 0, "2_ge_1");
        drive(0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 1, "m2_lt_m1");
        drive(0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, "m1_ge_m2");
        drive(0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1, 0, "m2_eq");
        drive(0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 0, 1, "m1_lt_max");
        drive(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 0, "max_ge_m1");
        drive(0, 32'h8000_0000, 32'h7FFF_FFFF, 0, 1, "min_lt_max");
        drive(0, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0, "max_ge_min");
        drive(0, 32'h8000_0000, 32'h8000_0000, 1, 0, "min_eq");
        drive(0, 32'h8000_0000, 32'd0, 0, 1, "min_lt_0");
        drive(0, 32'd0, 32'h8000_0000, 0, 0, "0_ge_min");
        drive(0, 32'd5, 32'd5, 1, 0, "reg_5_5");
        drive(0, 32'd3, 32'd9, 0, 1, "reg_3_9");
        drive(1, 32'd7, 32'd7, 1, 0, "rst_mid_eq");
        drive(0, 32'd7, 32'd7, 1, 0, "rst_release");
        drive(0, 32'd9, 32'd3, 0, 0, "9_ge_3");

        for (int i = 0; i < 1000; i++) begin
            ra = $random;
            rb = $random;
            if (i % 50 == 0) rb = ra;
            drive(0, ra, rb, ra == rb ? 1'b1 : 1'b0,
                  $signed(ra) < $signed(rb) ? 1'b1 : 1'b0, "rand");
        end

        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        n_cmp++;
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        @(negedge clk);
        #2;
        driver_done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/signed_compare_unit.md
Name: signed_compare_unit

Overview:
- Signed N-bit magnitude/equality comparator combining an equality comparator and a signed less-than comparator in one block.
- Outputs are provided two ways: combinational (same-cycle, for datapath use such as ALU SLT/branch decisions) and registered (one-cycle latency, for pipelined consumers).
- Built from gate-level primitives: XNOR reduction for equality, ripple subtract with overflow correction for less-than. No behavioural "<" or "==" operators.

Parameters:
- N, 32, operand width in bits; legal range N >= 2.

Ports:
- clk  input  1  rising-edge clock for the registered outputs.
- rst  input  1  synchronous active-high reset; affects only the registered outputs.
- a  input  N  operand A, two's-complement signed.
- b  input  N  operand B, two's-complement signed.
- equals  output  1  combinational: 1 iff a == b.
- less_than  output  1  combinational: 1 iff a < b, signed.
- equals_q  output  1  equals, registered.
- less_than_q  output  1  less_than, registered.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- equals:
  - bitwise XNOR of a and b, AND-reduced across all N bits.
  - Purely combinational; settles within the same evaluation with no clock dependence.
- less_than:
  - compute d = a + ~b + 1 (N-bit ripple-carry subtract, full-adder chain, carry-in 1).
  - overflow v = (a[N-1] != b[N-1]) AND (d[N-1] != a[N-1]).
  - less_than = d[N-1] XOR v.
  - Purely combinational; correct for every operand pair, including mixed signs and the most-negative value.
- Both combinational outputs are 0 or 1 for any fully-known inputs; never X or Z.
- Registered outputs:
  - on each rising clk, if rst = 1 then equals_q <= 0 and less_than_q <= 0.
  - otherwise equals_q <= equals and less_than_q <= less_than.
  - Latency is exactly 1 cycle: inputs sampled at edge k appear on the _q outputs after edge k.
- Reset:
  - rst has no effect on the combinational outputs.
  - Asserting rst mid-stream clears the _q outputs at the next edge.
  - The first edge after rst deasserts loads the current comparison.
- Reset values: equals_q = 0, less_than_q = 0. Combinational outputs have no reset value; they always reflect a and b.
- Mutual exclusion: equals and less_than are never both 1; the same holds for the _q pair.
- Boundary conditions:
  - a = b for any value: equals = 1, less_than = 0.
  - a = 0x80000000, b = 0x7FFFFFFF (N = 32): subtraction overflows; less_than = 1.
  - a = 0x7FFFFFFF, b = 0x80000000: less_than = 0.
- Timing: no internal state other than the two output flops.

Test Plan:
- a = 0, b = 0; then a = 38273, b = 38273 -> equals = 1, less_than = 0 both times.
- a = -1, b = 1 -> equals = 0, less_than = 1.
- Swapped signs and magnitudes:
  - a = 1, b = 2 -> less_than = 1.
  - a = 2, b = 1 -> less_than = 0.
  - a = -2, b = -1 -> less_than = 1.
  - a = -1, b = -2 -> less_than = 0.
  - a = -2, b = -2 -> equals = 1.
- Extremes:
  - a = 0xFFFFFFFF, b = 0x7FFFFFFF -> less_than = 1.
  - a = 0x7FFFFFFF, b = 0xFFFFFFFF -> less_than = 0.
  - a = 0x80000000, b = 0x7FFFFFFF -> less_than = 1.
  - a = 0x80000000, b = 0x80000000 -> equals = 1.
- Registered path:
  - hold rst = 1 for 2 cycles -> equals_q = less_than_q = 0.
  - release rst, apply a = 5, b = 5 -> equals_q = 1 one edge later.
  - next apply a = 3, b = 9 -> less_than_q = 1 one edge later.
  - assert rst while a = b -> equals_q = 0 at the next edge.
- Random: at least 1000 $random pairs, compared against signed behavioural a < b and a == b.
  - Check all four outputs with === (no X/Z).
  - Check the _q outputs one cycle delayed.
